// File: rtl/pos_cell_ctrl.sv
// Sequencer and single-port arbiter for one cell position RAM: serves a
// count-then-particles read stream and a motion-update write port.
module pos_cell_ctrl #(
  parameter int unsigned DATA_WIDTH   = 96,
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned PARTICLE_NUM = 220,
  parameter int unsigned RD_LATENCY   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_start,
  output logic                  rd_busy,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] rd_pid,
  output logic                  rd_done,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_gnt,
  output logic                  cnt_err,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_rden,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q
);

  typedef enum logic [2:0] {
    IDLE, WR, RD_CNT, CNT_WAIT, STREAM, DRAIN
  } state_t;

  localparam int unsigned            WW        = $clog2(RD_LATENCY) + 1;
  localparam logic [WW-1:0]          WAIT_LAST = WW'(RD_LATENCY - 1);
  localparam logic [ADDR_WIDTH-1:0]  CNT_MAX   = ADDR_WIDTH'(PARTICLE_NUM - 1);

  state_t                                 state_q, state_d;
  logic [WW-1:0]                          wait_q, wait_d;
  logic [ADDR_WIDTH-1:0]                  count_q, count_d;
  logic                                   err_q, err_d;
  logic                                   pend_q, pend_d;
  logic [ADDR_WIDTH-1:0]                  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]                  data_q, data_d;
  logic                                   rden_q, rden_d;
  logic                                   wren_q, wren_d;
  logic [RD_LATENCY-1:0]                  vld_q, vld_d;
  logic [RD_LATENCY-1:0][ADDR_WIDTH-1:0]  pid_q, pid_d;

  logic [ADDR_WIDTH-1:0] cnt_raw, cnt_clamped;
  logic                  cnt_over, wait_last;

  always_comb begin
    cnt_raw     = mem_q[ADDR_WIDTH-1:0];
    cnt_over    = cnt_raw > CNT_MAX;
    cnt_clamped = cnt_over ? CNT_MAX : cnt_raw;
    wait_last   = (wait_q == WAIT_LAST);

    state_d = state_q;
    wait_d  = wait_q;
    count_d = count_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        if (wr_req)                  state_d = WR;
        else if (rd_start || pend_q) state_d = RD_CNT;
      end
      WR:     state_d = (pend_q || rd_start) ? RD_CNT : IDLE;
      RD_CNT: begin
        state_d = CNT_WAIT;
        wait_d  = '0;
      end
      CNT_WAIT: begin
        if (wait_last) begin
          count_d = cnt_clamped;
          err_d   = err_q | cnt_over;
          state_d = (cnt_clamped != '0) ? STREAM : IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      STREAM: begin
        if (addr_q == count_q) begin
          state_d = DRAIN;
          wait_d  = '0;
        end
      end
      DRAIN: begin
        if (wait_last) state_d = IDLE;
        else           wait_d  = wait_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // A read request is consumed only by entering RD_CNT; otherwise it merges into pend.
    pend_d = (state_d == RD_CNT) ? 1'b0 : (pend_q | rd_start);

    // RAM-side outputs are registered from the next state.
    rden_d = (state_d == RD_CNT) || (state_d == STREAM);
    wren_d = (state_d == WR);
    data_d = (state_d == WR) ? wr_data : '0;
    unique case (state_d)
      WR:      addr_d = wr_addr;
      STREAM:  addr_d = (state_q == STREAM) ? addr_q + 1'b1 : ADDR_WIDTH'(1);
      default: addr_d = '0;
    endcase

    vld_d    = '0;
    pid_d    = '0;
    vld_d[0] = (state_q == STREAM);
    pid_d[0] = addr_q;
    for (int unsigned i = 1; i < RD_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      pid_d[i] = pid_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wait_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      pend_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      rden_q  <= 1'b0;
      wren_q  <= 1'b0;
      vld_q   <= '0;
      pid_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      count_q <= count_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rden_q  <= rden_d;
      wren_q  <= wren_d;
      vld_q   <= vld_d;
      pid_q   <= pid_d;
    end
  end

  // Count-0 completion is decided from mem_q in the last wait cycle itself.
  assign rd_done = ((state_q == CNT_WAIT) && wait_last && (cnt_clamped == '0)) ||
                   ((state_q == DRAIN) && wait_last);
  assign rd_busy     = (state_q == RD_CNT) || (state_q == CNT_WAIT) ||
                       (state_q == STREAM) || (state_q == DRAIN);
  assign rd_valid    = vld_q[RD_LATENCY-1];
  assign rd_pid      = pid_q[RD_LATENCY-1];
  assign rd_data     = mem_q;
  assign wr_gnt      = wren_q;
  assign cnt_err     = err_q;
  assign mem_address = addr_q;
  assign mem_data    = data_q;
  assign mem_rden    = rden_q;
  assign mem_wren    = wren_q;

endmodule

// File: tb/tb_pos_cell_ctrl.sv
// Self-checking bench for pos_cell_ctrl: behavioural RAM plus a reference
// model of the expected stream derived from the intended memory contents.
module tb_pos_cell_ctrl;
  localparam int DW = 96;
  localparam int AW = 8;
  localparam int PN = 220;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rd_start = 1'b0;
  logic          rd_busy, rd_valid, rd_done, wr_gnt, cnt_err;
  logic [DW-1:0] rd_data, mem_data, mem_q;
  logic [AW-1:0] rd_pid, mem_address;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          mem_rden, mem_wren;

  int checks = 0;
  int failures = 0;
  bit err_ref = 1'b0;

  logic [DW-1:0] ram     [256];
  logic [DW-1:0] ref_mem [256];
  logic [AW-1:0] ram_a;
  logic          ram_r;
  logic [DW-1:0] ram_q;

  always #5 clk = ~clk;

  pos_cell_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PARTICLE_NUM(PN), .RD_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .rd_start(rd_start), .rd_busy(rd_busy), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_pid(rd_pid), .rd_done(rd_done), .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_gnt(wr_gnt), .cnt_err(cnt_err), .mem_address(mem_address),
    .mem_data(mem_data), .mem_rden(mem_rden), .mem_wren(mem_wren), .mem_q(mem_q)
  );

  // Two-cycle synchronous RAM: address registered, then q registered.
  always @(posedge clk) begin
    if (mem_wren) ram[mem_address] <= mem_data;
    ram_a <= mem_address;
    ram_r <= mem_rden;
    if (ram_r) ram_q <= ram[ram_a];
  end
  assign mem_q = ram_q;

  function automatic int exp_count();
    int v;
    v = int'(ref_mem[0][AW-1:0]);
    return (v > PN - 1) ? PN - 1 : v;
  endfunction

  task automatic preload(input int cnt);
    for (int k = 0; k < 256; k++) begin
      ref_mem[k] = (k == 0) ? DW'(cnt) : {$urandom, $urandom, $urandom};
      ram[k] = ref_mem[k];
    end
  endtask

  // One full stream started in cycle 0; optional write raised mid-stream and
  // optional second rd_start pulse that must be served right after.
  task automatic run_stream(input int wr_cycle, input logic [AW-1:0] waddr,
                            input logic [DW-1:0] wdata, input int pend_cycle);
    int n, len, gnt_cycle, beats;
    bit over, drop, seen;
    logic [6:0] exp_v, act_v;
    n = exp_count();
    over = ref_mem[0][AW-1:0] > AW'(PN - 1);
    len = 8 + n;
    gnt_cycle = 7 + n;
    drop = 1'b0;
    @(posedge clk); #1 rd_start = 1'b1;
    for (int c = 1; c <= len; c++) begin
      @(posedge clk); #1;
      rd_start = (c == pend_cycle);
      if (c == wr_cycle) begin
        wr_req = 1'b1; wr_addr = waddr; wr_data = wdata;
      end
      if (drop) begin
        wr_req = 1'b0; drop = 1'b0;
      end
      @(negedge clk);
      if (over && c >= 4) err_ref = 1'b1;
      exp_v[6] = (n > 0) && c >= 6 && c <= 5 + n;
      exp_v[5] = (n == 0) ? (c == 3) : (c == 5 + n);
      exp_v[4] = ((n == 0) ? (c <= 3) : (c <= 5 + n)) || (pend_cycle > 0 && c >= 7 + n);
      exp_v[3] = (c == 1) || (n > 0 && c >= 4 && c <= 3 + n) || (pend_cycle > 0 && c == 7 + n);
      exp_v[2] = (wr_cycle > 0) && (c == gnt_cycle);
      exp_v[1] = exp_v[2];
      exp_v[0] = err_ref;
      act_v = {rd_valid, rd_done, rd_busy, mem_rden, mem_wren, wr_gnt, cnt_err};
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL ctrl{valid,done,busy,rden,wren,gnt,err} cnt=%0d c=%0d got=%b exp=%b", n, c, act_v, exp_v);
      end
      if (exp_v[6]) begin
        checks++;
        if (rd_pid !== AW'(c - 5) || rd_data !== ref_mem[c - 5]) begin
          failures++;
          $display("FAIL beat c=%0d pid got=%0d exp=%0d data got=%h exp=%h", c, rd_pid, c - 5, rd_data, ref_mem[c - 5]);
        end
      end
      if (exp_v[3] || exp_v[2]) begin
        checks++;
        if (mem_address !== (exp_v[2] ? waddr : (c >= 4 && c <= 3 + n) ? AW'(c - 3) : AW'(0))) begin
          failures++;
          $display("FAIL mem_address c=%0d got=%0d", c, mem_address);
        end
      end
      if (exp_v[2]) begin
        checks++;
        if (mem_data !== wdata) begin
          failures++;
          $display("FAIL mem_data c=%0d got=%h exp=%h", c, mem_data, wdata);
        end
        ref_mem[waddr] = wdata;
        drop = 1'b1;
      end
    end
    #1 rd_start = 1'b0;
    wr_req = 1'b0;
    if (pend_cycle > 0) begin
      seen = 1'b0; beats = 0;
      for (int t = 0; t < 400 && !seen; t++) begin
        @(negedge clk);
        if (rd_valid) beats++;
        if (rd_done) seen = 1'b1;
      end
      checks++;
      if (!seen || beats != n) begin
        failures++;
        $display("FAIL pending_stream done=%0b beats got=%0d exp=%0d", seen, beats, n);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({rd_busy, rd_valid, rd_done, wr_gnt, cnt_err, mem_rden, mem_wren} !== 7'b0 ||
        mem_address !== '0 || mem_data !== '0 || rd_pid !== '0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%b valid=%b addr=%0d exp=0", rd_busy, rd_valid, mem_address);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_count3();
    preload(3); run_stream(0, '0, '0, 0);
  endtask

  task automatic test_count0();
    preload(0); run_stream(0, '0, '0, 0);
  endtask

  task automatic test_clamp();
    preload(250); run_stream(0, '0, '0, 0);
    preload(3);   run_stream(0, '0, '0, 0);
  endtask

  task automatic test_write_priority();
    bit seen;
    preload(6);
    @(posedge clk); #1;
    rd_start = 1'b1; wr_req = 1'b1; wr_addr = AW'(5); wr_data = DW'(12'hABC);
    @(posedge clk); #1 rd_start = 1'b0;
    @(negedge clk);
    checks++;
    if ({wr_gnt, mem_wren, mem_rden} !== 3'b110 || mem_address !== AW'(5) || mem_data !== DW'(12'hABC)) begin
      failures++;
      $display("FAIL wr_first gnt=%b wren=%b rden=%b addr=%0d exp gnt=1 wren=1 rden=0 addr=5", wr_gnt, mem_wren, mem_rden, mem_address);
    end
    ref_mem[5] = DW'(12'hABC);
    @(posedge clk); #1 wr_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_rden, rd_busy, wr_gnt} !== 3'b110 || mem_address !== '0) begin
      failures++;
      $display("FAIL rd_after_wr rden=%b busy=%b gnt=%b addr=%0d exp rden=1 busy=1 gnt=0 addr=0", mem_rden, rd_busy, wr_gnt, mem_address);
    end
    seen = 1'b0;
    for (int t = 0; t < 50 && !seen; t++) begin
      @(negedge clk);
      if (rd_done) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL wr_prio_done got=0 exp=1");
    end
    @(negedge clk);
    run_stream(0, '0, '0, 0);
  endtask

  task automatic test_wr_midstream();
    preload(10);
    run_stream(6, AW'($urandom_range(1, 10)), {$urandom, $urandom, $urandom}, 0);
    run_stream(0, '0, '0, 0);
  endtask

  task automatic test_back_to_back();
    preload(2); run_stream(0, '0, '0, 3);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      preload($urandom_range(0, 15));
      run_stream(0, '0, '0, 0);
    end
  endtask

  task automatic test_reset_mid();
    preload(20);
    @(posedge clk); #1 rd_start = 1'b1;
    @(posedge clk); #1 rd_start = 1'b0;
    repeat (9) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({rd_busy, rd_valid, rd_done, wr_gnt, cnt_err, mem_rden, mem_wren} !== 7'b0 ||
        mem_address !== '0 || rd_pid !== '0) begin
      failures++;
      $display("FAIL reset_mid_outputs busy=%b valid=%b rden=%b addr=%0d exp=0", rd_busy, rd_valid, mem_rden, mem_address);
    end
    err_ref = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      checks++;
      if ({rd_valid, rd_done, rd_busy, mem_rden} !== 4'b0) begin
        failures++;
        $display("FAIL post_reset t=%0d valid=%b done=%b busy=%b rden=%b exp=0", t, rd_valid, rd_done, rd_busy, mem_rden);
      end
    end
    preload(4); run_stream(0, '0, '0, 0);
  endtask

  initial begin
    test_reset();
    test_count3();
    test_count0();
    test_clamp();
    test_write_priority();
    test_wr_midstream();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout global bound reached");
    $fatal(1, "timeout");
  end

endmodule
